fetch_prefetch_queue: RTL and testbench



---
 rtl/fetch_prefetch_queue.sv | 132 +++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction-fetch front end. It holds the fetch PC and
// issues sequential requests with at most one outstanding. Returned
// instructions, tagged with their PCs, are buffered in a DEPTH-entry queue and
// handed to decode through a valid/ready handshake. A redirect flushes the
// queue and discards any in-flight response.
// Optional feature: define FETCH_BYPASS_EN to forward a kept response straight
// to decode when the queue is empty.
module fetch_prefetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               inicio,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               id_ready
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   r_req_pc;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [INSTR_W-1:0]  r_q_instr [DEPTH];
  logic [ADDR_W-1:0]   r_q_pc    [DEPTH];

  logic                w_keep;
  logic                w_q_valid;
  logic                w_bypass;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic [CNT_W-1:0]    w_used;

  // A response in WAIT already owns a slot: whether it arrives now or later it
  // ends up in the queue. Counting it here keeps a new request from being
  // issued into the slot that the arriving response is about to fill.
  assign w_used    = r_count + {{(CNT_W-1){1'b0}}, (r_state == S_WAIT)};
  assign w_keep    = (r_state == S_WAIT) && imem_rvalid && !redirect;
  assign w_q_valid = (r_count != '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass  = w_keep && !w_q_valid;
`else
  assign w_bypass  = 1'b0;
`endif

  // Issue only when the memory port is free this cycle (idle, or the
  // outstanding response is retiring) and a queue slot is guaranteed.
  assign w_issue   = !inicio && !redirect &&
                     ((r_state == S_IDLE) || imem_rvalid) &&
                     (w_used < CNT_W'(DEPTH));

  assign imem_req    = w_issue;
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = !redirect && (w_q_valid || w_bypass);
  assign w_pop       = instr_valid && id_ready && w_q_valid;
  assign w_push      = w_keep && !(w_bypass && id_ready);

  // Decode outputs come from the queue head; zeroed when nothing is valid.
  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (instr_valid) begin
      if (w_q_valid) begin
        instr    = r_q_instr[r_rd_ptr];
        instr_pc = r_q_pc[r_rd_ptr];
      end else begin
        instr    = imem_rdata;
        instr_pc = r_req_pc;
      end
    end
  end

  // Fetch FSM, fetch PC, and queue occupancy/pointer bookkeeping.
  always_ff @(posedge clk or posedge inicio) begin
    if (inicio) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fetch_pc <= redirect_pc;
      r_state    <= ((r_state != S_IDLE) && !imem_rvalid) ? S_DROP : S_IDLE;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
        r_req_pc   <= r_fetch_pc;
        r_state    <= S_WAIT;
      end else if (imem_rvalid) begin
        r_state    <= S_IDLE;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents are only meaningful below r_count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_rdata;
      r_q_pc[r_wr_ptr]    <= r_req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: behavioural memory with programmable
// latency, an in-order delivery scoreboard, a per-cycle vector table and
// hand-written redirect / reset sequences.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        inicio = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        id_ready = 1'b1;

  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  logic        s_req = 1'b0;
  logic [31:0] s_addr = '0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  int          wcnt = 0;
  logic [31:0] exp_pc = RPC;
  bit          found;

  typedef struct packed {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  vec_t tv [11];

  always #5 clk = ~clk;

  fetch_prefetch_queue #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .inicio(inicio),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .id_ready(id_ready)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory model plus delivery scoreboard. Inputs change at the falling edge;
  // everything is sampled 3 time units later, well before the rising edge.
  always begin
    @(negedge clk);
    if (imem_rvalid) pend = 1'b0;
    if (s_req) begin
      pend  = 1'b1;
      paddr = s_addr;
      wcnt  = lat - 1;
    end else if (pend && wcnt > 0) begin
      wcnt--;
    end
    imem_rvalid = pend && (wcnt == 0);
    imem_rdata  = imem_rvalid ? memval(paddr) : '0;
    #3;
    s_req  = imem_req;
    s_addr = imem_addr;
    if (inicio) begin
      exp_pc = RPC;
    end else if (redirect) begin
      chk("redirect_blank", 32'(instr_valid), 32'd0);
      exp_pc = redirect_pc;
    end else if (instr_valid && id_ready) begin
      chk("deliver_pc", instr_pc, exp_pc);
      chk("deliver_instr", instr, memval(exp_pc));
      exp_pc += 32'd4;
    end
  end

  // Assert reset asynchronously, check outputs clear at once, then hold it.
  task automatic reset_dut(input int l);
    @(negedge clk);
    redirect = 1'b0;
    id_ready = 1'b1;
    lat      = l;
    inicio   = 1'b1;
    #1;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  imem_addr, RPC);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc",    instr_pc, 32'd0);
    repeat (5) @(negedge clk);
  endtask

  // One cycle: drive inputs at the falling edge, return at the sample point.
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    inicio      = 1'b0;
    id_ready    = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #3;
  endtask

  initial begin
`ifdef FETCH_BYPASS_EN
    tv[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 1'b1, 32'h104, 1'b1, 32'h100};
    tv[2]  = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
    tv[3]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h108};
    tv[4]  = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h10C};
    tv[5]  = '{1'b0, 1'b1, 32'h114, 1'b1, 32'h10C};
    tv[6]  = '{1'b0, 1'b1, 32'h118, 1'b1, 32'h10C};
    tv[7]  = '{1'b0, 1'b0, 32'h11C, 1'b1, 32'h10C};
    tv[8]  = '{1'b1, 1'b0, 32'h11C, 1'b1, 32'h10C};
    tv[9]  = '{1'b1, 1'b1, 32'h11C, 1'b1, 32'h110};
    tv[10] = '{1'b1, 1'b1, 32'h120, 1'b1, 32'h114};
`else
    tv[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    tv[2]  = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    tv[3]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
    tv[4]  = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h108};
    tv[5]  = '{1'b0, 1'b1, 32'h114, 1'b1, 32'h108};
    tv[6]  = '{1'b0, 1'b0, 32'h118, 1'b1, 32'h108};
    tv[7]  = '{1'b0, 1'b0, 32'h118, 1'b1, 32'h108};
    tv[8]  = '{1'b1, 1'b0, 32'h118, 1'b1, 32'h108};
    tv[9]  = '{1'b1, 1'b1, 32'h118, 1'b1, 32'h10C};
    tv[10] = '{1'b1, 1'b1, 32'h11C, 1'b1, 32'h110};
`endif

    // Streaming at L=1, then stall with a full queue, then release.
    reset_dut(1);
    for (int i = 0; i < 11; i++) begin
      step(tv[i].rdy, 1'b0, 32'h0);
      chk($sformatf("v%0d_req", i),   32'(imem_req), 32'(tv[i].req));
      chk($sformatf("v%0d_addr", i),  imem_addr, tv[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(tv[i].v));
      if (tv[i].v) chk($sformatf("v%0d_pc", i), instr_pc, tv[i].pc);
    end

    // Reset with entries queued, restart at RESET_PC with L=3.
    reset_dut(3);
    step(1'b1, 1'b0, 32'h0);
    chk("restart_req",  32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, RPC);

    // Redirect while the request to 0x10C is outstanding.
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      step(1'b1, 1'b0, 32'h0);
      if (imem_req && imem_addr == 32'h10C) found = 1'b1;
    end
    chk("wait_req_10c", 32'(found), 32'd1);
    step(1'b1, 1'b1, 32'h400);
    chk("rd_req_off", 32'(imem_req), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("drop_req_off", 32'(imem_req), 32'd0);
    chk("drop_addr",    imem_addr, 32'h400);
    chk("drop_empty",   32'(instr_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("drop_rvalid",  32'(imem_rvalid), 32'd1);
    chk("drop_reissue", 32'(imem_req), 32'd1);
    chk("drop_addr2",   imem_addr, 32'h400);
    chk("drop_discard", 32'(instr_valid), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b1, 1'b0, 32'h0);
      if (instr_valid) found = 1'b1;
    end
    chk("after_rd_seen", 32'(found), 32'd1);
    chk("after_rd_pc",   instr_pc, 32'h400);

    // Redirect coinciding with a response and a would-be pop, L=1.
    reset_dut(1);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h200);
    chk("rdrv_rvalid", 32'(imem_rvalid), 32'd1);
    chk("rdrv_valid",  32'(instr_valid), 32'd0);
    chk("rdrv_req",    32'(imem_req), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("rdrv_next_req",  32'(imem_req), 32'd1);
    chk("rdrv_next_addr", imem_addr, 32'h200);
    chk("rdrv_next_vld",  32'(instr_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("byp_rvalid", 32'(imem_rvalid), 32'd1);
`ifdef FETCH_BYPASS_EN
    chk("byp_valid", 32'(instr_valid), 32'd1);
    chk("byp_pc",    instr_pc, 32'h200);
    step(1'b1, 1'b0, 32'h0);
    chk("byp_pc2",   instr_pc, 32'h204);
`else
    chk("byp_valid", 32'(instr_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("byp_valid2", 32'(instr_valid), 32'd1);
    chk("byp_pc2",    instr_pc, 32'h200);
`endif
    repeat (4) step(1'b1, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
